// File: rtl/arena_pkg.sv
// Shared arena map definitions: map geometry, element codes and layout helpers
// used by the map controller, the draw path and game logic.
package arena_pkg;

   localparam int MAP_W   = 16;
   localparam int MAP_H   = 16;
   localparam int EL_W    = 3;
   localparam int ADDR_W  = 8;
   localparam int N_CELLS = MAP_W * MAP_H;

   localparam logic [EL_W-1:0] EL_EMPTY = 3'd0;
   localparam logic [EL_W-1:0] EL_WALL  = 3'd1;
   localparam logic [EL_W-1:0] EL_BLOCK = 3'd2;
   localparam logic [EL_W-1:0] EL_BOMB  = 3'd3;
   localparam logic [EL_W-1:0] EL_FIRE  = 3'd4;

   typedef enum logic {ST_INIT, ST_RUN} map_state_e;

   // Border cells and every (even x, even y) pillar are indestructible.
   function automatic logic is_wall(input logic [ADDR_W-1:0] addr);
      logic [3:0] x;
      logic [3:0] y;
      x = addr[3:0];
      y = addr[7:4];
      return (x == 4'd0) || (x == 4'd15) || (y == 4'd0) || (y == 4'd15) ||
             (!x[0] && !y[0]);
   endfunction

   function automatic logic is_spawn(input logic [ADDR_W-1:0] addr);
      return (addr == 8'h11) || (addr == 8'h12) || (addr == 8'h21) ||
             (addr == 8'hEE) || (addr == 8'hED) || (addr == 8'hDE);
   endfunction

endpackage

// File: rtl/arena_rr_arb.sv
// Round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping modulo N_REQ; one-hot grant plus its binary index.
module arena_rr_arb #(
   parameter int N_REQ = 2,
   parameter int PTR_W = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic             en,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PTR_W-1:0] grant_idx
);

   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = PTR_W'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arena_map_ctrl.sv
// Arena tile map owner: draw read port, round-robin requester access and
// layout (re)initialisation. Define ARENA_MAP_RAND_EN for LFSR-scattered blocks.
//
// state   | meaning
// ST_INIT | sweep writes default layout cell by cell, draw forced EMPTY, no grants
// ST_RUN  | requesters arbitrated, one access per cycle
module arena_map_ctrl
   import arena_pkg::*;
#(
   parameter int          N_REQ     = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                 i_pclk,
   input  logic                 i_rst,
   input  logic [7:0]           i_draw_addr,
   output logic [2:0]           o_draw_data,
   input  logic [N_REQ-1:0]     i_req,
   input  logic [N_REQ-1:0]     i_we,
   input  logic [8*N_REQ-1:0]   i_addr,
   input  logic [3*N_REQ-1:0]   i_wdata,
   output logic [N_REQ-1:0]     o_ack,
   output logic [2:0]           o_rdata,
   input  logic                 i_clear,
   output logic                 o_busy
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   map_state_e         state_q, state_d;
   logic [ADDR_W-1:0]  ctr_q, ctr_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic [EL_W-1:0]    rdata_q, rdata_d;
   logic [EL_W-1:0]    draw_q, draw_d;
   logic               busy_q, busy_d;

   logic [EL_W-1:0]    mem_q [N_CELLS];
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_waddr;
   logic [EL_W-1:0]    mem_wdata;

   logic [N_REQ-1:0]   grant;
   logic [PTR_W-1:0]   grant_idx;
   logic [ADDR_W-1:0]  sel_addr;
   logic [EL_W-1:0]    sel_wdata;
   logic               sel_we;
   logic [EL_W-1:0]    init_el;

   // A requester is not eligible while its previous ack is on the output.
   arena_rr_arb #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
      .req       (i_req & ~ack_q),
      .en        (state_q == ST_RUN),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign sel_addr  = i_addr[8*grant_idx +: 8];
   assign sel_wdata = i_wdata[3*grant_idx +: 3];
   assign sel_we    = i_we[grant_idx];

`ifdef ARENA_MAP_RAND_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (state_q == ST_INIT)
         lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      else if (i_clear)
         lfsr_d = LFSR_SEED;
   end

   always_ff @(posedge i_pclk) begin
      if (i_rst) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign init_el = is_wall(ctr_q)          ? EL_WALL  :
                    is_spawn(ctr_q)         ? EL_EMPTY :
                    (lfsr_q[1:0] != 2'd0)   ? EL_BLOCK : EL_EMPTY;
`else
   logic [15:0] unused_seed;
   assign unused_seed = LFSR_SEED;
   assign init_el     = is_wall(ctr_q) ? EL_WALL : EL_EMPTY;
`endif

   always_comb begin
      state_d   = state_q;
      ctr_d     = ctr_q;
      ptr_d     = ptr_q;
      ack_d     = '0;
      rdata_d   = rdata_q;
      mem_we    = 1'b0;
      mem_waddr = ctr_q;
      mem_wdata = init_el;
      case (state_q)
         ST_INIT: begin
            mem_we = 1'b1;
            ctr_d  = ctr_q + 8'd1;
            if (ctr_q == 8'hFF) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (|grant) begin
               ack_d     = grant;
               rdata_d   = mem_q[sel_addr];
               mem_we    = sel_we;
               mem_waddr = sel_addr;
               mem_wdata = sel_wdata;
               ptr_d     = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            // An access accepted this cycle lands before the sweep starts.
            if (i_clear) begin
               state_d = ST_INIT;
               ctr_d   = '0;
            end
         end
         default: state_d = ST_INIT;
      endcase
      busy_d = (state_d == ST_INIT);
      draw_d = busy_d ? EL_EMPTY : mem_q[i_draw_addr];
   end

   always_ff @(posedge i_pclk) begin
      if (i_rst) begin
         state_q <= ST_INIT;
         ctr_q   <= '0;
         ptr_q   <= '0;
         ack_q   <= '0;
         rdata_q <= EL_EMPTY;
         draw_q  <= EL_EMPTY;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         draw_q  <= draw_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge i_pclk) begin
      if (mem_we && !i_rst) mem_q[mem_waddr] <= mem_wdata;
   end

   assign o_draw_data = draw_q;
   assign o_ack       = ack_q;
   assign o_rdata     = rdata_q;
   assign o_busy      = busy_q;

endmodule
